// File: rtl/fcmp_unpack_stage_pkg.sv
// Shared FP definitions for the compare-unit front end: format widths,
// canonical NaNs, the compare opcode and the unpacked-operand record.
package fcmp_unpack_stage_pkg;

    localparam int FLEN = 64;
    localparam int NE   = 11;
    localparam int NF   = 52;
    localparam int S_NE = 8;
    localparam int S_NF = 23;

    localparam logic [31:0]     CANON_SNAN = 32'h7FC0_0000;
    localparam logic [FLEN-1:0] CANON_DNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {
        OP_FMIN = 3'd0,
        OP_FMAX = 3'd1,
        OP_FEQ  = 3'd2,
        OP_FLT  = 3'd3,
        OP_FLE  = 3'd4,
        OP_FLTQ = 3'd5,
        OP_FLEQ = 3'd6,
        OP_RSVD = 3'd7
    } fcmp_op_e;

    typedef struct packed {
        logic            s;
        logic [NE-1:0]   e;
        logic [NF:0]     m;
        logic            zero;
        logic            nan;
        logic            snan;
        logic [FLEN-1:0] raw;
    } fp_unpacked_t;

    typedef struct packed {
        logic         fmt;
        fcmp_op_e     opctrl;
        logic         zfa;
        fp_unpacked_t x;
        fp_unpacked_t y;
    } stage_entry_t;

    function automatic logic [FLEN-1:0] box_single(input logic [31:0] w);
        return {32'hFFFF_FFFF, w};
    endfunction

endpackage

// File: rtl/fp_operand_unpack.sv
// Combinational decode of one raw register-file operand into sign, widened
// exponent, mantissa and zero/NaN/sNaN classes; single values are widened to double layout.
module fp_operand_unpack
    import fcmp_unpack_stage_pkg::*;
(
    input  logic            fmt_i,
    input  logic [FLEN-1:0] x_i,
    output fp_unpacked_t    op_o
);

    logic [31:0]     sw;
    logic [S_NE-1:0] se;
    logic [S_NF-1:0] sf;
    logic [NE-1:0]   de;
    logic [NF-1:0]   df;

    always_comb begin
        // An improperly boxed single reads as the canonical quiet NaN.
        sw = (&x_i[FLEN-1:32]) ? x_i[31:0] : CANON_SNAN;
        se = sw[S_NE+S_NF-1:S_NF];
        sf = sw[S_NF-1:0];
        de = x_i[NE+NF-1:NF];
        df = x_i[NF-1:0];
        op_o = '0;
        if (fmt_i) begin
            op_o.s    = x_i[FLEN-1];
            op_o.e    = de;
            op_o.m    = {|de, df};
            op_o.zero = (de == '0) && (df == '0);
            op_o.nan  = (&de) && (df != '0);
            op_o.snan = (&de) && (df != '0) && !df[NF-1];
            op_o.raw  = x_i;
        end else begin
            // Rebias by inserting inverted copies of the exponent MSB: monotonic, 0 -> 896.
            op_o.s    = sw[31];
            op_o.e    = {se[S_NE-1], {(NE-S_NE){~se[S_NE-1]}}, se[S_NE-2:0]};
            op_o.m    = {|se, sf, {(NF-S_NF){1'b0}}};
            op_o.zero = (se == '0) && (sf == '0);
            op_o.nan  = (&se) && (sf != '0);
            op_o.snan = (&se) && (sf != '0) && !sf[S_NF-1];
            op_o.raw  = box_single(sw);
        end
    end

endmodule

// File: rtl/fcmp_unpack_stage.sv
// Registered unpack stage in front of the FP compare unit: decodes both operands
// and holds them in a main register backed by a skid register so in_ready stays registered.
module fcmp_unpack_stage
    import fcmp_unpack_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FLEN-1:0] in_x,
    input  logic [FLEN-1:0] in_y,
    input  logic            in_fmt,
    input  logic [2:0]      in_opctrl,
    input  logic            in_zfa,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_fmt,
    output logic [2:0]      out_opctrl,
    output logic            out_zfa,
    output logic            out_xs,
    output logic            out_ys,
    output logic [NE-1:0]   out_xe,
    output logic [NE-1:0]   out_ye,
    output logic [NF:0]     out_xm,
    output logic [NF:0]     out_ym,
    output logic            out_xzero,
    output logic            out_yzero,
    output logic            out_xnan,
    output logic            out_ynan,
    output logic            out_xsnan,
    output logic            out_ysnan,
    output logic [FLEN-1:0] out_x,
    output logic [FLEN-1:0] out_y
);

    fp_unpacked_t x_unp;
    fp_unpacked_t y_unp;
    stage_entry_t in_entry;
    stage_entry_t main_q, main_d;
    stage_entry_t skid_q, skid_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         accept;
    logic         drain;

    fp_operand_unpack u_unpack_x (.fmt_i(in_fmt), .x_i(in_x), .op_o(x_unp));
    fp_operand_unpack u_unpack_y (.fmt_i(in_fmt), .x_i(in_y), .op_o(y_unp));

    always_comb begin
        in_entry.fmt    = in_fmt;
        in_entry.opctrl = fcmp_op_e'(in_opctrl);
        in_entry.zfa    = in_zfa;
        in_entry.x      = x_unp;
        in_entry.y      = y_unp;
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid_q & out_ready;

    // The skid register is only ever occupied while main is also occupied.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (drain) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q && !drain) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid  = main_valid_q;
    assign out_fmt    = main_q.fmt;
    assign out_opctrl = main_q.opctrl;
    assign out_zfa    = main_q.zfa;
    assign out_xs     = main_q.x.s;
    assign out_ys     = main_q.y.s;
    assign out_xe     = main_q.x.e;
    assign out_ye     = main_q.y.e;
    assign out_xm     = main_q.x.m;
    assign out_ym     = main_q.y.m;
    assign out_xzero  = main_q.x.zero;
    assign out_yzero  = main_q.y.zero;
    assign out_xnan   = main_q.x.nan;
    assign out_ynan   = main_q.y.nan;
    assign out_xsnan  = main_q.x.snan;
    assign out_ysnan  = main_q.y.snan;
    assign out_x      = main_q.x.raw;
    assign out_y      = main_q.y.raw;

endmodule

// File: tb/tb_fcmp_unpack_stage.sv
// Self-checking bench for fcmp_unpack_stage: directed scenarios plus random traffic
// scored against a 2-deep FIFO model with arithmetic operand decoding.
module tb_fcmp_unpack_stage;
    import fcmp_unpack_stage_pkg::*;

    localparam int OPW = 132;
    localparam int TW  = 5 + 2 * OPW;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_x = '0;
    logic [63:0] in_y = '0;
    logic        in_fmt = 1'b0;
    logic [2:0]  in_opctrl = '0;
    logic        in_zfa = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_fmt, out_zfa, out_xs, out_ys;
    logic [2:0]  out_opctrl;
    logic [10:0] out_xe, out_ye;
    logic [52:0] out_xm, out_ym;
    logic        out_xzero, out_yzero, out_xnan, out_ynan, out_xsnan, out_ysnan;
    logic [63:0] out_x, out_y;

    logic [TW-1:0] obs;
    logic [TW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int ntx = 0;

    fcmp_unpack_stage dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_fmt(in_fmt), .in_opctrl(in_opctrl), .in_zfa(in_zfa),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fmt(out_fmt), .out_opctrl(out_opctrl), .out_zfa(out_zfa),
        .out_xs(out_xs), .out_ys(out_ys), .out_xe(out_xe), .out_ye(out_ye),
        .out_xm(out_xm), .out_ym(out_ym),
        .out_xzero(out_xzero), .out_yzero(out_yzero),
        .out_xnan(out_xnan), .out_ynan(out_ynan),
        .out_xsnan(out_xsnan), .out_ysnan(out_ysnan),
        .out_x(out_x), .out_y(out_y)
    );

    assign obs = {out_fmt, out_opctrl, out_zfa,
                  out_xs, out_xe, out_xm, out_xzero, out_xnan, out_xsnan, out_x,
                  out_ys, out_ye, out_ym, out_yzero, out_ynan, out_ysnan, out_y};

    always #5 clk = ~clk;

    // Reference decode: IEEE field arithmetic, singles rebiased by +896 (1023-127).
    function automatic logic [OPW-1:0] ref_op(input logic fmt, input logic [63:0] x);
        logic [63:0] raw, frac;
        logic [31:0] w;
        logic [52:0] m;
        logic [10:0] e;
        logic        s, zero, nan, snan;
        int unsigned be, se, f;
        if (fmt) begin
            s    = x[63];
            be   = int'(x[62:52]);
            frac = {12'd0, x[51:0]};
            e    = 11'(be);
            m    = 53'(frac) + ((be != 0) ? (53'd1 << 52) : 53'd0);
            zero = (be == 0) && (frac == 0);
            nan  = (be == 2047) && (frac != 0);
            snan = nan && (frac < (64'd1 << 51));
            raw  = x;
        end else begin
            w    = (x[63:32] == 32'hFFFF_FFFF) ? x[31:0] : 32'h7FC0_0000;
            s    = w[31];
            se   = int'(w[30:23]);
            f    = int'(w[22:0]);
            e    = 11'(se + 896);
            m    = (53'(f) + ((se != 0) ? (53'd1 << 23) : 53'd0)) << 29;
            zero = (se == 0) && (f == 0);
            nan  = (se == 255) && (f != 0);
            snan = nan && (f < (1 << 22));
            raw  = {32'hFFFF_FFFF, w};
        end
        return {s, e, m, zero, nan, snan, raw};
    endfunction

    function automatic logic [TW-1:0] ref_txn(input logic fmt, input logic [2:0] op, input logic zfa,
                                              input logic [63:0] x, input logic [63:0] y);
        return {fmt, op, zfa, ref_op(fmt, x), ref_op(fmt, y)};
    endfunction

    function automatic logic [63:0] rand_opnd();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 6))
            1: r[63:32] = '1;
            2: begin r[63:32] = '1; r[30:23] = '1; end
            3: begin r[63:32] = '1; r[30:0] = '0; end
            4: r[62:52] = '1;
            5: r[62:0] = '0;
            6: begin r[63:32] = '1; r[30:0] = 31'h7F80_0000; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chkw(input string tag, input logic [TW-1:0] o, input logic [TW-1:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(exp_q.size() > 0));
        chk({tag, "_ready"}, 64'(in_ready), 64'(exp_q.size() < 2));
        if (exp_q.size() > 0) chkw({tag, "_data"}, obs, exp_q[0]);
    endtask

    // One clock of traffic: drive, check at the falling edge, then advance the model.
    task automatic step(input string tag, input logic v, input logic [63:0] x, input logic [63:0] y,
                        input logic fmt, input logic [2:0] op, input logic zfa,
                        input logic ordy, input logic fl, output logic acc);
        logic drn;
        in_valid = v; in_x = x; in_y = y; in_fmt = fmt;
        in_opctrl = op; in_zfa = zfa; out_ready = ordy; flush = fl;
        @(negedge clk);
        check_state(tag);
        acc = v && !fl && (exp_q.size() < 2);
        drn = (exp_q.size() > 0) && ordy;
        if (drn && !fl) begin
            ntx++;
            $display("[TB] %s tx %0d op=%0d x=%h y=%h", tag, ntx, out_opctrl, out_x, out_y);
        end
        @(posedge clk);
        if (fl) exp_q.delete();
        else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(ref_txn(fmt, op, zfa, x, y));
        end
        #1;
    endtask

    task automatic idle(input string tag, input logic ordy);
        logic a;
        step(tag, 1'b0, '0, '0, 1'b0, 3'd0, 1'b0, ordy, 1'b0, a);
    endtask

    initial begin
        logic a;
        logic [TW-1:0] snap;
        logic [63:0] ops[4];
        ops[0] = 64'h4000_0000_0000_0000;
        ops[1] = 64'hC008_0000_0000_0000;
        ops[2] = 64'h0000_0000_0000_0001;
        ops[3] = 64'hFFF4_0000_0000_0000;

        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chkw("rst_data", obs, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Double decode example
        step("dbl", 1'b1, 64'h3FF0_0000_0000_0000, 64'h7FF0_0000_0000_0001, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, a);
        chk("dbl_out_valid", 64'(out_valid), 64'd1);
        chk("dbl_xe", 64'(out_xe), 64'h3FF);
        chk("dbl_xm", 64'(out_xm), 64'd1 << 52);
        chk("dbl_ynan", 64'(out_ynan), 64'd1);
        chk("dbl_ysnan", 64'(out_ysnan), 64'd1);
        idle("dbl_gap", 1'b1);
        chk("dbl_one_cycle", 64'(out_valid), 64'd0);

        step("qnan", 1'b1, CANON_DNAN, 64'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, a);
        chk("qnan_xnan", 64'(out_xnan), 64'd1);
        chk("qnan_xsnan", 64'(out_xsnan), 64'd0);
        chk("qnan_yzero", 64'(out_yzero), 64'd1);

        // Single boxed / unboxed
        step("sgl_z", 1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_3F80_0000, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, a);
        chk("sgl_xs", 64'(out_xs), 64'd1);
        chk("sgl_xzero", 64'(out_xzero), 64'd1);
        chk("sgl_xe0", 64'(out_xe), 64'd896);
        step("sgl_inf", 1'b1, 64'hFFFF_FFFF_7F80_0000, 64'hFFFF_FFFF_7F80_0001, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, a);
        chk("sgl_xe255", 64'(out_xe), 64'd1151);
        chk("sgl_xnan", 64'(out_xnan), 64'd0);
        chk("sgl_ysnan", 64'(out_ysnan), 64'd1);
        step("unbox", 1'b1, 64'h0000_0000_3F80_0000, 64'h1234_5678_FFFF_FFFF, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, a);
        chk("unbox_xnan", 64'(out_xnan), 64'd1);
        chk("unbox_xsnan", 64'(out_xsnan), 64'd0);
        chk("unbox_x", out_x, 64'hFFFF_FFFF_7FC0_0000);
        idle("unbox_gap", 1'b1);

        // Backpressure: A,B fill both registers, C,D wait for room
        step("bp_a", 1'b1, ops[0], ops[3], 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, a);
        step("bp_b", 1'b1, ops[1], ops[2], 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, a);
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        snap = obs;
        step("bp_stall", 1'b1, ops[2], ops[1], 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, a);
        chkw("bp_stable", obs, snap);
        for (int k = 2; k < 4; k++) begin
            a = 1'b0;
            for (int t = 0; t < 8 && !a; t++)
                step("bp_cd", 1'b1, ops[k], ops[3-k], 1'b1, 3'(k), 1'b0, 1'b1, 1'b0, a);
        end
        repeat (4) idle("bp_drain", 1'b1);

        // Flush with both registers full and an op on the input
        step("fl_a", 1'b1, ops[0], ops[1], 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, a);
        step("fl_b", 1'b1, ops[1], ops[0], 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, a);
        step("fl", 1'b1, ops[2], ops[2], 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, a);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        idle("fl_after", 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step("rnd", $urandom_range(0, 3) != 0, rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0, a);
        repeat (3) idle("rnd_drain", 1'b1);

        // Asynchronous reset mid-stream
        step("ar_a", 1'b1, ops[0], ops[1], 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, a);
        step("ar_b", 1'b1, ops[1], ops[0], 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, a);
        #2;
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_ready", 64'(in_ready), 64'd1);
        chkw("ar_data", obs, '0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        step("ar_post", 1'b1, ops[3], ops[2], 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, a);
        chk("ar_post_valid", 64'(out_valid), 64'd1);
        chk("ar_post_x", out_x, ops[3]);
        repeat (2) idle("ar_drain", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fcmp_unpack_stage.md
Name: fcmp_unpack_stage

Overview:
- Registered operand-unpack stage directly upstream of the FP compare unit (fmin/fmax/feq/flt/fle, Zfa variants).
- Accepts raw FLEN-wide register-file operands plus op controls over a valid/ready handshake.
- Checks NaN-boxing, decodes sign/exponent/mantissa and the zero/NaN/sNaN classes, and presents registered fields to the compare unit one cycle later.
- A 2-entry skid buffer decouples downstream backpressure from the upstream ready path.

Parameters:
- FLEN, 64: operand width (double).
- NE, 11: exponent width presented downstream.
- NF, 52: fraction width presented downstream (mantissa NF+1 bits including the implicit bit).
- S_NE, 8: single-precision exponent width.
- S_NF, 23: single-precision fraction width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; drops all buffered entries
- in_valid  in  1  upstream has an op
- in_ready  out  1  stage can accept
- in_x, in_y  in  FLEN  raw operands
- in_fmt  in  1  1=double, 0=single
- in_opctrl  in  3  compare opcode, passed through
- in_zfa  in  1  Zfa variant flag, passed through
- out_valid  out  1  registered op available
- out_ready  in  1  compare/writeback consumes
- out_fmt, out_opctrl, out_zfa  out  1/3/1  registered pass-through
- out_xs, out_ys  out  1  signs
- out_xe, out_ye  out  NE  exponents
- out_xm, out_ym  out  NF+1  mantissas
- out_xzero, out_yzero, out_xnan, out_ynan, out_xsnan, out_ysnan  out  1  classes
- out_x, out_y  out  FLEN  normalised raw operands for the equality compare

Behaviour:
- Reset: reset_n low asynchronously clears both entry valid bits. Out: out_valid=0, in_ready=1, all data outputs 0.
- Handshake:
  - A transfer occurs when valid&ready on a cycle edge.
  - Latency 1: an op accepted at edge N is visible at out_* after edge N.
  - Throughput 1/cycle while out_ready=1.
  - out_* must hold stable while out_valid&~out_ready.
- Buffer: main register plus skid register. in_ready = ~skid_valid (registered, not combinational from out_ready).
  - Accept while main full and not draining: the entry goes to skid.
  - Drain: skid moves to main.
  - Simultaneous accept and drain with skid empty: main is replaced.
  - Both full: in_ready=0.
  - Ordering is strictly FIFO.
- flush: next edge clears both valids and the accepting transfer is discarded. flush has priority over in_valid. reset_n has priority over flush.
- Unpack, double (fmt=1):
  - s=x[63], e=x[62:52], frac=x[51:0].
  - m={|e, frac}.
  - zero = (e==0)&(frac==0).
  - nan = (&e)&(frac!=0).
  - snan = nan&~frac[51].
  - out_x = in_x.
- Unpack, single (fmt=0), boxed (x[63:32]==32'hFFFFFFFF):
  - se=x[30:23].
  - e={se[7], {3{~se[7]}}, se[6:0]}; order-preserving; 0 maps to 896.
  - m={|se, x[22:0], 29'b0}.
  - nan = (&se)&(x[22:0]!=0).
  - snan = nan&~x[22].
  - zero = (se==0)&(x[22:0]==0).
  - out_x = {32'hFFFFFFFF, x[31:0]}.
- Single, unboxed: treated as canonical qNaN 0x7FC00000 (s=0, nan=1, snan=0, zero=0), and out_x = 64'hFFFFFFFF7FC00000.
- Y operand is decoded identically.
- Upper-32 contents never affect a boxed single result.
- Classification is computed before registering; no combinational path from in_* to out_*.

Decomposition:
- Shared FP package holds the format constants (NE/NF, S_NE/S_NF, canonical single/double NaN), the opcode enum for OpCtrl, and a packed struct for the unpacked operand {s,e,m,zero,nan,snan,raw}.
- One sub-module, fp_operand_unpack: combinational, one operand, instantiated twice.
- The skid buffer stays inline.

Test Plan:
- Double: x=0x3FF0000000000000, y=0x7FF0000000000001, fmt=1, out_ready=1 -> next cycle: out_xe=0x3FF, out_xm=1<<52, out_ynan=1, out_ysnan=1, out_valid=1 for one cycle.
- Single boxed: x=0xFFFFFFFF80000000 -> out_xs=1, out_xzero=1, out_xe=896. x=0xFFFFFFFF7F800000 -> out_xe=1151, out_xnan=0.
- Single unboxed: x=0x000000003F800000 -> out_xnan=1, out_xsnan=0, out_x=0xFFFFFFFF7FC00000.
- Backpressure: stream 4 ops with out_ready=0 -> in_ready falls after 2 accepts. out_ready=1 -> ops emerge in order A,B,C,D with no loss or duplication, and out_* stays stable while stalled.
- Flush: main+skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the in-flight op is dropped.
- Async reset mid-stream: reset_n low between edges -> out_valid=0 immediately, all outputs 0. After release, the first accept appears 1 cycle later.
